// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
package hazard_pkg;
   typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
   typedef enum logic {IDLE, MUL} mul_state_t;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: EX operand forwarding select for one source register, MEM over WB.
module fwd_sel
   import hazard_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] src_i,
   input  logic [AW-1:0] mem_addr_i,
   input  logic          mem_we_i,
   input  logic [AW-1:0] wb_addr_i,
   input  logic          wb_we_i,
   output fwd_sel_t      sel_o
);
   always_comb
      sel_o = (mem_we_i && mem_addr_i != '0 && mem_addr_i == src_i) ? FWD_MEM :
              (wb_we_i && wb_addr_i != '0 && wb_addr_i == src_i)    ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall, branch flush and multiplier stall control.
// Define HAZARD_PERF_EN to add saturating StallCount/FlushCount outputs.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int AW      = 5,
   parameter int MUL_LAT = 4
) (
   input  logic          Clock,
   input  logic          nReset,
   input  logic [AW-1:0] RsAddrD,
   input  logic [AW-1:0] RtAddrD,
   input  logic [AW-1:0] RsAddrE,
   input  logic [AW-1:0] RtAddrE,
   input  logic [AW-1:0] RAddrE,
   input  logic          RegWriteE,
   input  logic          MemReadE,
   input  logic          MulOpE,
   input  logic          BranchTakenE,
   input  logic [AW-1:0] RAddrM,
   input  logic          RegWriteM,
   input  logic [AW-1:0] RAddrW,
   input  logic          RegWriteW,
   output logic          StallF,
   output logic          StallD,
   output logic          StallE,
   output logic          FlushD,
   output logic          FlushE,
   output logic          FlushM,
   output logic [1:0]    FwdAE,
   output logic [1:0]    FwdBE,
`ifdef HAZARD_PERF_EN
   output logic          MulBusy,
   output logic [31:0]   StallCount,
   output logic [31:0]   FlushCount
`else
   output logic          MulBusy
`endif
);
   localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

   mul_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lu, lu_eff, mul_start, mul_stall;
   fwd_sel_t      fwd_a, fwd_b;

   fwd_sel #(.AW(AW)) u_fwd_a (
      .src_i(RsAddrE), .mem_addr_i(RAddrM), .mem_we_i(RegWriteM),
      .wb_addr_i(RAddrW), .wb_we_i(RegWriteW), .sel_o(fwd_a)
   );
   fwd_sel #(.AW(AW)) u_fwd_b (
      .src_i(RtAddrE), .mem_addr_i(RAddrM), .mem_we_i(RegWriteM),
      .wb_addr_i(RAddrW), .wb_we_i(RegWriteW), .sel_o(fwd_b)
   );

   // A taken branch squashes EX, so neither the multiply nor the load-use stall may start.
   always_comb begin
      lu        = MemReadE && RegWriteE && RAddrE != '0 && (RAddrE == RsAddrD || RAddrE == RtAddrD);
      mul_start = state_q == IDLE && MulOpE && !BranchTakenE && MUL_LAT > 1;
      mul_stall = mul_start || (state_q == MUL && cnt_q != '0);
      lu_eff    = lu && !BranchTakenE && state_q == IDLE && !mul_start;
      state_d   = mul_start ? MUL : (state_q == MUL && cnt_q == '0) ? IDLE : state_q;
      cnt_d     = mul_start ? CNT_INIT : (state_q == MUL && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      StallF    = lu_eff || mul_stall;
      StallD    = lu_eff || mul_stall;
      StallE    = mul_stall;
      FlushD    = BranchTakenE;
      FlushE    = BranchTakenE || lu_eff;
      FlushM    = mul_stall;
      FwdAE     = fwd_a;
      FwdBE     = fwd_b;
      MulBusy   = state_q == MUL;
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (StallF && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 32'd1;
         if ((FlushD || FlushE) && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;
`endif
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline hazard controller for the 5-stage core (IF/DEC/EX/MEM/WB).
- Generates EX-stage operand forwarding selects, load-use stalls, branch-taken flushes and multi-cycle multiplier stalls.
- Drives the stall/flush inputs of the inter-stage PIPE registers and the EX operand muxes. Sits beside the datapath in PROCESSOR.

Parameters:
- AW, 5, register-address width.
- MUL_LAT, 4, cycles a multiply occupies EX (≥1). Cycle counter width is max(1,$clog2(MUL_LAT)).

Ports:
- Clock  input  1  system clock, rising edge
- nReset  input  1  asynchronous active-low reset
- RsAddrD  input  AW  Rs of instruction in DEC
- RtAddrD  input  AW  Rt of instruction in DEC
- RsAddrE  input  AW  Rs of instruction in EX
- RtAddrE  input  AW  Rt of instruction in EX
- RAddrE  input  AW  destination of instruction in EX
- RegWriteE  input  1  EX instruction writes a register
- MemReadE  input  1  EX instruction is a load
- MulOpE  input  1  EX instruction is a multiply
- BranchTakenE  input  1  branch/jump resolved taken in EX
- RAddrM  input  AW  destination in MEM
- RegWriteM  input  1  MEM instruction writes a register
- RAddrW  input  AW  destination in WB
- RegWriteW  input  1  WB instruction writes a register
- StallF  output  1  hold PC
- StallD  output  1  hold IF/DEC pipe
- StallE  output  1  hold DEC/EX pipe
- FlushD  output  1  zero IF/DEC pipe next edge
- FlushE  output  1  zero DEC/EX pipe next edge (bubble)
- FlushM  output  1  zero EX/MEM pipe next edge (bubble)
- FwdAE  output  2  Rs operand select: 00 regfile, 01 WB, 10 MEM
- FwdBE  output  2  Rt operand select, same encoding
- MulBusy  output  1  multiplier FSM is in MUL state

Behaviour:
- Reset: state IDLE, counter 0.
  - All outputs are combinational from state and inputs.
  - With IDLE state and all-zero inputs, every output is 0.
  - Async reset mid-multiply returns to IDLE immediately; stalls drop the same cycle.
- Forwarding (combinational, per operand):
  - 10 if RegWriteM && RAddrM!=0 && RAddrM==RsAddrE (resp. RtAddrE).
  - Else 01 if RegWriteW && RAddrW!=0 && RAddrW matches.
  - Else 00. MEM has priority over WB.
- Load-use:
  - Condition: lu = MemReadE && RegWriteE && RAddrE!=0 && (RAddrE==RsAddrD || RAddrE==RtAddrD).
  - On lu: StallF=StallD=1, FlushE=1 for exactly one cycle.
  - Suppressed while state is MUL or a multiply starts this cycle.
- Branch: BranchTakenE → FlushD=FlushE=1 in the same cycle. Overrides lu (no stall, the dependent instruction is squashed).
- Multiplier FSM, states IDLE and MUL:
  - IDLE, MulOpE=1, MUL_LAT>1: assert StallF/D/E and FlushM; load cnt=MUL_LAT-2; go MUL.
  - IDLE, MulOpE=1, MUL_LAT==1: no stall, stay IDLE.
  - MUL, cnt!=0: assert StallF/D/E and FlushM; cnt--.
  - MUL, cnt==0: no stall; go IDLE. MulOpE is ignored in MUL.
  - Total stall cycles per multiply = MUL_LAT-1. Back-to-back multiplies each get a full MUL_LAT.
- Simultaneous BranchTakenE and MulOpE cannot occur (single EX slot). If both are seen, branch flush wins and the FSM does not start.
- Forwarding outputs remain valid during stalls.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs StallCount[31:0] and FlushCount[31:0].
  - Saturating counters, reset 0.
  - StallCount increments each cycle StallF=1.
  - FlushCount increments each cycle FlushD|FlushE=1.
- Undefined: ports and logic absent.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
  - mul_state_t enum {IDLE, MUL}.
- Sub-module fwd_sel: one operand's comparator/priority logic, instantiated twice (A and B).

Test Plan:
- RAddrM=3, RegWriteM=1, RAddrW=3, RegWriteW=1, RsAddrE=3 → FwdAE=10. Set RAddrM=0 → FwdAE=01.
- Load to r5 in EX, RtAddrD=5 → StallF=StallD=FlushE=1 for one cycle, then 0. Same with RAddrE=0 → no stall.
- MUL_LAT=4, MulOpE held high → StallE/FlushM high for cycles 0–2, low in cycle 3. MulBusy high in cycles 1–3.
- Load-use and BranchTakenE in the same cycle → FlushD=FlushE=1, StallF=0.
- nReset pulsed low during MUL (cnt=1) → stalls drop immediately. After release, state is IDLE.
- HAZARD_PERF_EN: 3 load-use events plus one 4-cycle multiply → StallCount=6. Then 2 branches → FlushCount=5 (includes the 3 load-use FlushE).
